// File: rtl/mdio_peripheral_mp_pkg.sv
// Shared constants and FSM state encoding for the Clause 22 MDIO management peripheral.
package mdio_peripheral_mp_pkg;

    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] ST_PATTERN = 2'b01;
    localparam logic [1:0] TA_WRITE   = 2'b10;

    localparam int FRAME_DATA_BITS = 16;

    typedef enum logic [3:0] {
        S_PRE   = 4'd0,
        S_ST    = 4'd1,
        S_OP    = 4'd2,
        S_PHYAD = 4'd3,
        S_REGAD = 4'd4,
        S_TA    = 4'd5,
        S_WDATA = 4'd6,
        S_RDATA = 4'd7,
        S_SKIP  = 4'd8
    } mdio_state_e;

endpackage

// File: rtl/mdio_peripheral_mp_shifter.sv
// 16-bit serial shifter (SIPO/PISO with parallel load) plus a 5-bit bit counter with terminal-count flag.
module mdio_peripheral_mp_shifter
    import mdio_peripheral_mp_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [FRAME_DATA_BITS-1:0] load_val,
    input  logic                       shift,
    input  logic                       sin,
    input  logic                       cnt_clr,
    input  logic                       cnt_inc,
    input  logic [4:0]                 tc_val,
    output logic [FRAME_DATA_BITS-1:0] q,
    output logic                       tc
);

    logic [FRAME_DATA_BITS-1:0] q_r;
    logic [4:0]                 cnt_r;

    // Shift register and bit counter; load wins over shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r   <= {FRAME_DATA_BITS{1'b0}};
            cnt_r <= 5'd0;
        end else begin
            if (load) begin
                q_r <= load_val;
            end else if (shift) begin
                q_r <= {q_r[FRAME_DATA_BITS-2:0], sin};
            end else begin
                q_r <= q_r;
            end
            if (cnt_clr) begin
                cnt_r <= 5'd0;
            end else if (cnt_inc) begin
                cnt_r <= cnt_r + 5'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign q  = q_r;
    assign tc = (cnt_r == tc_val);

endmodule

// File: rtl/mdio_peripheral_mp.sv
// Clause 22 MDIO PHY-side management slave clocked by MDC.
// Optional MDIO_PREAMBLE_SUPPRESS_EN: accept an ST with no preamble after a completed addressed frame.
module mdio_peripheral_mp
    import mdio_peripheral_mp_pkg::*;
#(
    parameter logic [4:0] PHY_BASE     = 5'h01,
    parameter int         NUM_PHY      = 1,
    parameter int         DATA_WIDTH   = 16,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic                  MDC,
    input  logic                  RESET,
    input  logic                  MDIO_OUT,
    input  logic                  MDIO_OE,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  MDIO_IN,
    output logic                  MDIO_IN_OE,
    output logic [4:0]            ADDR,
    output logic [4:0]            PHY_SEL,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  WR_STB,
    output logic                  RD_STB,
    output logic                  MDIO_DONE,
    output logic                  FRAME_ERR
);

    localparam logic [5:0] PRE_LEN = 6'(PREAMBLE_LEN);
    localparam logic [5:0] NUM6    = 6'(NUM_PHY);

    mdio_state_e state_r, state_nxt;
    logic [5:0]  pre_cnt_r, pre_cnt_nxt;
    logic        is_read_r, is_read_nxt, match_r, match_nxt;
    logic        mdio_in_r, mdio_in_nxt, mdio_in_oe_r, mdio_in_oe_nxt;
    logic [4:0]  addr_r, addr_nxt, phy_sel_r, phy_sel_nxt;
    logic [DATA_WIDTH-1:0] wr_data_r, wr_data_nxt;
    logic        wr_stb_r, wr_stb_nxt, rd_stb_r, rd_stb_nxt;
    logic        done_r, done_nxt, err_r, err_nxt;

    logic        line_s, sup_s, match_s;
    logic [4:0]  phyad_s, phy_off_s;
    logic [FRAME_DATA_BITS-1:0] sh_q_s, rd16_s, wdat16_s;
    logic        sh_load_s, sh_shift_s, sh_sin_s, cnt_clr_s, cnt_inc_s, sh_tc_s;
    logic [4:0]  tc_val_s;

    // A released line reads as 1 through the pull-up.
    assign line_s    = MDIO_OE ? MDIO_OUT : 1'b1;
    assign phyad_s   = {sh_q_s[3:0], line_s};
    assign phy_off_s = phyad_s - PHY_BASE;
    assign match_s   = (phyad_s >= PHY_BASE) && ({1'b0, phy_off_s} < NUM6);
    assign rd16_s    = FRAME_DATA_BITS'(RD_DATA);
    assign wdat16_s  = {sh_q_s[FRAME_DATA_BITS-2:0], line_s};

    mdio_peripheral_mp_shifter u_shifter (
        .clk      (MDC),
        .reset    (RESET),
        .load     (sh_load_s),
        .load_val (rd16_s),
        .shift    (sh_shift_s),
        .sin      (sh_sin_s),
        .cnt_clr  (cnt_clr_s),
        .cnt_inc  (cnt_inc_s),
        .tc_val   (tc_val_s),
        .q        (sh_q_s),
        .tc       (sh_tc_s)
    );

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic sup_r, sup_nxt;

    // Suppression arms on a completed frame and disarms on any frame error.
    always_comb begin
        sup_nxt = sup_r;
        if (err_nxt) begin
            sup_nxt = 1'b0;
        end else if (done_nxt) begin
            sup_nxt = 1'b1;
        end else begin
            sup_nxt = sup_r;
        end
    end

    // Preamble-suppression flag register.
    always_ff @(posedge MDC) begin
        if (RESET) begin
            sup_r <= 1'b0;
        end else begin
            sup_r <= sup_nxt;
        end
    end

    assign sup_s = sup_r;
`else
    assign sup_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge MDC) begin
        if (RESET) begin
            state_r <= S_PRE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Frame parser: next state, shifter control and next values of all output registers.
    always_comb begin
        state_nxt      = state_r;
        pre_cnt_nxt    = pre_cnt_r;
        is_read_nxt    = is_read_r;
        match_nxt      = match_r;
        mdio_in_nxt    = mdio_in_r;
        mdio_in_oe_nxt = mdio_in_oe_r;
        addr_nxt       = addr_r;
        phy_sel_nxt    = phy_sel_r;
        wr_data_nxt    = wr_data_r;
        wr_stb_nxt     = 1'b0;
        rd_stb_nxt     = 1'b0;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        sh_load_s      = 1'b0;
        sh_shift_s     = 1'b0;
        sh_sin_s       = line_s;
        cnt_clr_s      = 1'b0;
        cnt_inc_s      = 1'b0;
        tc_val_s       = 5'd0;
        case (state_r)
            S_PRE: begin
                cnt_clr_s = 1'b1;
                if (line_s) begin
                    pre_cnt_nxt = (pre_cnt_r == PRE_LEN) ? pre_cnt_r : pre_cnt_r + 6'd1;
                end else if ((pre_cnt_r == PRE_LEN) || sup_s) begin
                    pre_cnt_nxt = 6'd0;
                    state_nxt   = S_ST;
                end else begin
                    pre_cnt_nxt = 6'd0;
                end
            end
            S_ST: begin
                cnt_clr_s = 1'b1;
                if ({1'b0, line_s} == ST_PATTERN) begin
                    state_nxt = S_OP;
                end else begin
                    state_nxt = S_PRE;
                end
            end
            S_OP: begin
                tc_val_s   = 5'd1;
                sh_shift_s = 1'b1;
                if (!sh_tc_s) begin
                    cnt_inc_s = 1'b1;
                end else if ({sh_q_s[0], line_s} == OP_WRITE || {sh_q_s[0], line_s} == OP_READ) begin
                    cnt_clr_s   = 1'b1;
                    is_read_nxt = ({sh_q_s[0], line_s} == OP_READ);
                    state_nxt   = S_PHYAD;
                end else begin
                    cnt_clr_s = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = S_PRE;
                end
            end
            S_PHYAD: begin
                tc_val_s   = 5'd4;
                sh_shift_s = 1'b1;
                if (sh_tc_s) begin
                    cnt_clr_s   = 1'b1;
                    match_nxt   = match_s;
                    phy_sel_nxt = match_s ? phy_off_s : phy_sel_r;
                    state_nxt   = S_REGAD;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            S_REGAD: begin
                tc_val_s   = 5'd4;
                sh_shift_s = 1'b1;
                if (!sh_tc_s) begin
                    cnt_inc_s = 1'b1;
                end else if (match_r) begin
                    cnt_clr_s  = 1'b1;
                    addr_nxt   = {sh_q_s[3:0], line_s};
                    rd_stb_nxt = is_read_r;
                    state_nxt  = S_TA;
                end else begin
                    cnt_clr_s = 1'b1;
                    state_nxt = S_SKIP;
                end
            end
            S_TA: begin
                tc_val_s = 5'd1;
                if (is_read_r) begin
                    if (sh_tc_s) begin
                        cnt_clr_s   = 1'b1;
                        sh_shift_s  = 1'b1;
                        sh_sin_s    = 1'b0;
                        mdio_in_nxt = sh_q_s[FRAME_DATA_BITS-1];
                        state_nxt   = S_RDATA;
                    end else begin
                        cnt_inc_s      = 1'b1;
                        sh_load_s      = 1'b1;
                        mdio_in_oe_nxt = 1'b1;
                        mdio_in_nxt    = 1'b0;
                    end
                end else begin
                    sh_shift_s = 1'b1;
                    if (!sh_tc_s) begin
                        cnt_inc_s = 1'b1;
                    end else if ({sh_q_s[0], line_s} == TA_WRITE) begin
                        cnt_clr_s = 1'b1;
                        state_nxt = S_WDATA;
                    end else begin
                        cnt_clr_s = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = S_PRE;
                    end
                end
            end
            S_WDATA: begin
                tc_val_s   = 5'(FRAME_DATA_BITS - 1);
                sh_shift_s = 1'b1;
                if (sh_tc_s) begin
                    cnt_clr_s   = 1'b1;
                    wr_data_nxt = DATA_WIDTH'(wdat16_s);
                    wr_stb_nxt  = 1'b1;
                    done_nxt    = 1'b1;
                    state_nxt   = S_PRE;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            S_RDATA: begin
                tc_val_s = 5'(FRAME_DATA_BITS - 1);
                if (sh_tc_s) begin
                    cnt_clr_s      = 1'b1;
                    mdio_in_oe_nxt = 1'b0;
                    mdio_in_nxt    = 1'b1;
                    done_nxt       = 1'b1;
                    state_nxt      = S_PRE;
                end else begin
                    cnt_inc_s   = 1'b1;
                    sh_shift_s  = 1'b1;
                    sh_sin_s    = 1'b0;
                    mdio_in_nxt = sh_q_s[FRAME_DATA_BITS-1];
                end
            end
            S_SKIP: begin
                // TA plus data bits of a frame for another PHY.
                tc_val_s = 5'(FRAME_DATA_BITS + 1);
                if (sh_tc_s) begin
                    cnt_clr_s = 1'b1;
                    state_nxt = S_PRE;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            default: begin
                cnt_clr_s   = 1'b1;
                pre_cnt_nxt = 6'd0;
                state_nxt   = S_PRE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge MDC) begin
        if (RESET) begin
            pre_cnt_r    <= 6'd0;
            is_read_r    <= 1'b0;
            match_r      <= 1'b0;
            mdio_in_r    <= 1'b1;
            mdio_in_oe_r <= 1'b0;
            addr_r       <= 5'd0;
            phy_sel_r    <= 5'd0;
            wr_data_r    <= {DATA_WIDTH{1'b0}};
            wr_stb_r     <= 1'b0;
            rd_stb_r     <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            pre_cnt_r    <= pre_cnt_nxt;
            is_read_r    <= is_read_nxt;
            match_r      <= match_nxt;
            mdio_in_r    <= mdio_in_nxt;
            mdio_in_oe_r <= mdio_in_oe_nxt;
            addr_r       <= addr_nxt;
            phy_sel_r    <= phy_sel_nxt;
            wr_data_r    <= wr_data_nxt;
            wr_stb_r     <= wr_stb_nxt;
            rd_stb_r     <= rd_stb_nxt;
            done_r       <= done_nxt;
            err_r        <= err_nxt;
        end
    end

    assign MDIO_IN    = mdio_in_r;
    assign MDIO_IN_OE = mdio_in_oe_r;
    assign ADDR       = addr_r;
    assign PHY_SEL    = phy_sel_r;
    assign WR_DATA    = wr_data_r;
    assign WR_STB     = wr_stb_r;
    assign RD_STB     = rd_stb_r;
    assign MDIO_DONE  = done_r;
    assign FRAME_ERR  = err_r;

endmodule

// File: tb/tb_mdio_peripheral_mp.sv
// Directed bench for mdio_peripheral_mp (PHY_BASE=1, NUM_PHY=4); expectations follow MDIO_PREAMBLE_SUPPRESS_EN.
module tb_mdio_peripheral_mp;

    logic        MDC = 1'b0;
    logic        RESET;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        MDIO_IN;
    logic        MDIO_IN_OE;
    logic [4:0]  ADDR;
    logic [4:0]  PHY_SEL;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_STB;
    logic        MDIO_DONE;
    logic        FRAME_ERR;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, oe_cnt = 0;
    int w0, r0, d0, e0, o0;

    always #5 MDC = ~MDC;

    mdio_peripheral_mp #(
        .PHY_BASE     (5'h01),
        .NUM_PHY      (4),
        .DATA_WIDTH   (16),
        .PREAMBLE_LEN (32)
    ) dut (
        .MDC        (MDC),
        .RESET      (RESET),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_OE    (MDIO_OE),
        .RD_DATA    (RD_DATA),
        .MDIO_IN    (MDIO_IN),
        .MDIO_IN_OE (MDIO_IN_OE),
        .ADDR       (ADDR),
        .PHY_SEL    (PHY_SEL),
        .WR_DATA    (WR_DATA),
        .WR_STB     (WR_STB),
        .RD_STB     (RD_STB),
        .MDIO_DONE  (MDIO_DONE),
        .FRAME_ERR  (FRAME_ERR)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge MDC) begin
        if (WR_STB)     wr_cnt   <= wr_cnt + 1;
        if (RD_STB)     rd_cnt   <= rd_cnt + 1;
        if (MDIO_DONE)  done_cnt <= done_cnt + 1;
        if (FRAME_ERR)  err_cnt  <= err_cnt + 1;
        if (MDIO_IN_OE) oe_cnt   <= oe_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; o0 = oe_cnt;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge MDC);
            MDIO_OE  = 1'b1;
            MDIO_OUT = v[i];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge MDC);
            MDIO_OE  = 1'b0;
            MDIO_OUT = 1'b0;
        end
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d);
        for (int i = 0; i < pre; i++) send_bits(16'h0001, 1);
        send_bits(16'h0001, 2);
        send_bits({14'h0, op}, 2);
        send_bits({11'h0, phy}, 5);
        send_bits({11'h0, ra}, 5);
        send_bits({14'h0, ta}, 2);
        send_bits(d, 16);
    endtask

    task automatic rd_header(input logic [4:0] phy, input logic [4:0] ra);
        for (int i = 0; i < 32; i++) send_bits(16'h0001, 1);
        send_bits(16'h0001, 2);
        send_bits(16'h0002, 2);
        send_bits({11'h0, phy}, 5);
        send_bits({11'h0, ra}, 5);
    endtask

    task automatic read_slots(input logic [15:0] exp);
        logic [15:0] got;
        logic        oe_all;
        @(negedge MDC); MDIO_OE = 1'b0;
        chk("rd_stb_ta1", RD_STB, 1'b1);
        chk("rd_oe_ta1", MDIO_IN_OE, 1'b0);
        @(negedge MDC);
        chk("rd_oe_ta2", MDIO_IN_OE, 1'b1);
        chk("rd_in_ta2", MDIO_IN, 1'b0);
        got = 16'h0000;
        oe_all = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge MDC);
            oe_all = oe_all & MDIO_IN_OE;
            got = {got[14:0], MDIO_IN};
        end
        chk("rd_data", got, exp);
        chk("rd_data_oe", oe_all, 1'b1);
        @(negedge MDC);
        chk("rd_end_oe", MDIO_IN_OE, 1'b0);
        chk("rd_end_in", MDIO_IN, 1'b1);
        chk("rd_end_done", MDIO_DONE, 1'b1);
    endtask

    initial begin
        RESET = 1'b1; MDIO_OE = 1'b0; MDIO_OUT = 1'b0; RD_DATA = 16'h0000;
        repeat (3) @(negedge MDC);
        chk("rst_in", MDIO_IN, 1'b1);
        chk("rst_oe", MDIO_IN_OE, 1'b0);
        chk("rst_addr", ADDR, 5'h00);
        chk("rst_wdata", WR_DATA, 16'h0000);
        chk("rst_physel", PHY_SEL, 5'h00);
        chk("rst_pulses", {WR_STB, RD_STB, MDIO_DONE, FRAME_ERR}, 4'b0000);
        RESET = 1'b0;
        idle(4);

        // Write to PHY 1.
        snap();
        frame(32, 2'b01, 5'd1, 5'h10, 2'b10, 16'hABCD);
        idle(4);
        chk("t1_wr", 32'(wr_cnt - w0), 32'd1);
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_err", 32'(err_cnt - e0), 32'd0);
        chk("t1_addr", ADDR, 5'h10);
        chk("t1_wdata", WR_DATA, 16'hABCD);
        chk("t1_physel", PHY_SEL, 5'h00);

        // Read from PHY 1.
        snap();
        RD_DATA = 16'h1234;
        rd_header(5'd1, 5'h10);
        read_slots(16'h1234);
        idle(4);
        chk("t2_rd", 32'(rd_cnt - r0), 32'd1);
        chk("t2_done", 32'(done_cnt - d0), 32'd1);
        chk("t2_wr", 32'(wr_cnt - w0), 32'd0);

        // Foreign PHY read, then write to PHY 3.
        snap();
        rd_header(5'd7, 5'h10);
        idle(22);
        chk("t3_rd", 32'(rd_cnt - r0), 32'd0);
        chk("t3_oe", 32'(oe_cnt - o0), 32'd0);
        chk("t3_done", 32'(done_cnt - d0), 32'd0);
        snap();
        frame(32, 2'b01, 5'd3, 5'h04, 2'b10, 16'hFEED);
        idle(4);
        chk("t3_wr", 32'(wr_cnt - w0), 32'd1);
        chk("t3_physel", PHY_SEL, 5'h02);
        chk("t3_wdata", WR_DATA, 16'hFEED);
        chk("t3_addr", ADDR, 5'h04);

        // Bad OP.
        snap();
        frame(32, 2'b11, 5'd1, 5'h06, 2'b10, 16'h0F0F);
        idle(4);
        chk("t4_op_err", 32'(err_cnt - e0), 32'd1);
        chk("t4_op_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0) + (done_cnt - d0)), 32'd0);
        chk("t4_op_addr", ADDR, 5'h04);

        // Bad write TA.
        snap();
        frame(32, 2'b01, 5'd1, 5'h07, 2'b11, 16'h1357);
        idle(4);
        chk("t4_ta_err", 32'(err_cnt - e0), 32'd1);
        chk("t4_ta_wr", 32'(wr_cnt - w0), 32'd0);
        chk("t4_ta_done", 32'(done_cnt - d0), 32'd0);
        chk("t4_ta_wdata", WR_DATA, 16'hFEED);

        // Preamble one bit short.
        snap();
        send_bits(16'h0000, 2);
        frame(31, 2'b01, 5'd1, 5'h08, 2'b10, 16'h1111);
        idle(4);
        chk("t4_pre_wr", 32'(wr_cnt - w0), 32'd0);
        chk("t4_pre_done", 32'(done_cnt - d0), 32'd0);
        chk("t4_pre_err", 32'(err_cnt - e0), 32'd0);
        chk("t4_pre_wdata", WR_DATA, 16'hFEED);

        // Reset during read data bit 8.
        snap();
        RD_DATA = 16'hC3C3;
        rd_header(5'd1, 5'h02);
        for (int s = 1; s <= 10; s++) begin
            @(negedge MDC);
            MDIO_OE = 1'b0;
            if (s == 9) chk("t5_oe_before", MDIO_IN_OE, 1'b1);
            if (s == 10) RESET = 1'b1;
        end
        @(negedge MDC);
        chk("t5_oe", MDIO_IN_OE, 1'b0);
        chk("t5_in", MDIO_IN, 1'b1);
        chk("t5_addr", ADDR, 5'h00);
        chk("t5_wdata", WR_DATA, 16'h0000);
        chk("t5_physel", PHY_SEL, 5'h00);
        chk("t5_pulses", {WR_STB, RD_STB, MDIO_DONE, FRAME_ERR}, 4'b0000);
        RESET = 1'b0;
        idle(4);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        snap();
        frame(32, 2'b01, 5'd2, 5'h1F, 2'b10, 16'h8001);
        idle(4);
        chk("t5_wr", 32'(wr_cnt - w0), 32'd1);
        chk("t5_wdata2", WR_DATA, 16'h8001);
        chk("t5_addr2", ADDR, 5'h1F);
        chk("t5_physel2", PHY_SEL, 5'h01);

        // Write followed immediately by a frame with no preamble.
        snap();
        frame(32, 2'b01, 5'd1, 5'h0A, 2'b10, 16'h0F0F);
        frame(0, 2'b01, 5'd1, 5'h0B, 2'b10, 16'h5A5A);
        idle(4);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        chk("t6_wr", 32'(wr_cnt - w0), 32'd2);
        chk("t6_wdata", WR_DATA, 16'h5A5A);
        chk("t6_addr", ADDR, 5'h0B);
`else
        chk("t6_wr", 32'(wr_cnt - w0), 32'd1);
        chk("t6_wdata", WR_DATA, 16'h0F0F);
        chk("t6_addr", ADDR, 5'h0A);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
